matrix_engine: RTL and testbench

Parametrised successor of the fixed 3x3 nibble matrix unit. It accepts two N×N signed matrices and a three-beat configuration over a serial input stream, rotates each operand by a programmable number of quarter turns, and computes one operation: A+B, A−B, A×B or det(A). The result is streamed out one element per cycle. It sits between the serial stimulus port and the result collector, and unlike its predecessor it supports flow-controlled loading, wider data and selectable matrix size.

---
 rtl/matrix_engine.sv | 230 +++++++++++++++++++++++
 tb/tb_matrix_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_engine.sv
// Serial-loaded NxN signed matrix unit: rotates both operands by quarter turns,
// then computes A+B, A-B, AxB or det(A) and streams the result row-major.
module matrix_engine #(
    parameter int N  = 3,
    parameter int DW = 4,
    parameter int OW = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 IN_VALID,
    input  logic signed [DW-1:0] IN,
    output logic                 IN_READY,
    output logic                 OUT_VALID,
    output logic signed [OW-1:0] OUT
);
    localparam int NN = N * N;
    localparam int AW = 3 * DW + 2;   // covers every op's full-precision width
    localparam int CW = $clog2(NN);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_A   = 3'd1;
    localparam logic [2:0] S_LOAD_B   = 3'd2;
    localparam logic [2:0] S_LOAD_CFG = 3'd3;
    localparam logic [2:0] S_ROT      = 3'd4;
    localparam logic [2:0] S_COMPUTE  = 3'd5;
    localparam logic [2:0] S_OUT      = 3'd6;

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           cfg_q, cfg_d;
    logic [1:0]           ci_q, ci_d, cj_q, cj_d, ck_q, ck_d;
    logic [1:0]           rota_q, rota_d, rotb_q, rotb_d, op_q, op_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [DW-1:0] a_q [NN];
    logic signed [DW-1:0] a_d [NN];
    logic signed [DW-1:0] b_q [NN];
    logic signed [DW-1:0] b_d [NN];
    logic signed [DW-1:0] wa_q [NN];
    logic signed [DW-1:0] wa_d [NN];
    logic signed [DW-1:0] wb_q [NN];
    logic signed [DW-1:0] wb_d [NN];
    logic signed [OW-1:0] res_q [NN];
    logic signed [OW-1:0] res_d [NN];
    logic signed [AW-1:0] det_term;
    logic                 accept;

    function automatic logic signed [AW-1:0] wide(input logic signed [DW-1:0] x);
        return AW'(x);
    endfunction

    // Two's-complement wrap (or sign extension) of a full-precision value to OW bits.
    function automatic logic signed [OW-1:0] fit(input logic signed [AW-1:0] v);
        logic signed [AW+OW-1:0] e;
        e = (AW + OW)'(v);
        return e[OW-1:0];
    endfunction

    // Flat source index feeding R[r][c] after k clockwise quarter turns.
    function automatic int rot_src(input int r, input int c, input logic [1:0] k);
        case (k)
            2'd0:    return r * N + c;
            2'd1:    return (N - 1 - c) * N + r;
            2'd2:    return (N - 1 - r) * N + (N - 1 - c);
            default: return c * N + (N - 1 - r);
        endcase
    endfunction

    assign IN_READY  = (state_q == S_IDLE) || (state_q == S_LOAD_A) ||
                       (state_q == S_LOAD_B) || (state_q == S_LOAD_CFG);
    assign accept    = IN_VALID && IN_READY;
    assign OUT_VALID = (state_q == S_OUT);
    assign OUT       = OUT_VALID ? res_q[cnt_q] : '0;

    // One signed cofactor term per cycle, selected by ck.
    if (N == 2) begin : g_det2
        always_comb begin
            if (ck_q == 2'd0) det_term = wide(wa_q[0]) * wide(wa_q[3]);
            else              det_term = -(wide(wa_q[1]) * wide(wa_q[2]));
        end
    end else begin : g_det3
        always_comb begin
            int c, c1, c2;
            logic signed [AW-1:0] minor;
            c  = int'(ck_q);
            c1 = (c == 0) ? 1 : 0;
            c2 = (c == 2) ? 1 : 2;
            minor = wide(wa_q[3 + c1]) * wide(wa_q[6 + c2]) -
                    wide(wa_q[3 + c2]) * wide(wa_q[6 + c1]);
            det_term = c[0] ? -(wide(wa_q[c]) * minor) : wide(wa_q[c]) * minor;
        end
    end

    always_comb begin
        int i, j, k;
        logic signed [AW-1:0] s, p;
        logic last, step_ij;
        state_d = state_q;  cnt_d  = cnt_q;  cfg_d  = cfg_q;
        ci_d    = ci_q;     cj_d   = cj_q;   ck_d   = ck_q;
        rota_d  = rota_q;   rotb_d = rotb_q; op_d   = op_q;
        acc_d   = acc_q;
        a_d = a_q;  b_d = b_q;  wa_d = wa_q;  wb_d = wb_q;  res_d = res_q;
        i = int'(ci_q);  j = int'(cj_q);  k = int'(ck_q);
        s = '0;  p = '0;  last = 1'b0;  step_ij = 1'b0;
        case (state_q)
            S_IDLE, S_LOAD_A: if (accept) begin
                a_d[cnt_q] = IN;
                if (cnt_q == CW'(NN - 1)) begin
                    state_d = S_LOAD_B;
                    cnt_d   = '0;
                end else begin
                    state_d = S_LOAD_A;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_LOAD_B: if (accept) begin
                b_d[cnt_q] = IN;
                if (cnt_q == CW'(NN - 1)) begin
                    state_d = S_LOAD_CFG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOAD_CFG: if (accept) begin
                case (cfg_q)
                    2'd0:    rota_d = IN[1:0];
                    2'd1:    rotb_d = IN[1:0];
                    default: op_d   = IN[1:0];
                endcase
                if (cfg_q == 2'd2) begin
                    cfg_d   = '0;
                    state_d = S_ROT;
                end else begin
                    cfg_d = cfg_q + 1'b1;
                end
            end
            S_ROT: begin
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        wa_d[r * N + c] = a_q[rot_src(r, c, rota_q)];
                        wb_d[r * N + c] = b_q[rot_src(r, c, rotb_q)];
                    end
                end
                ci_d = '0;  cj_d = '0;  ck_d = '0;  acc_d = '0;
                state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                case (op_q)
                    2'd0, 2'd1: begin
                        s = op_q[0] ? wide(wa_q[i * N + j]) - wide(wb_q[i * N + j])
                                    : wide(wa_q[i * N + j]) + wide(wb_q[i * N + j]);
                        res_d[i * N + j] = fit(s);
                        step_ij = 1'b1;
                    end
                    2'd2: begin
                        p = wide(wa_q[i * N + k]) * wide(wb_q[k * N + j]);
                        s = ((ck_q == 2'd0) ? '0 : acc_q) + p;
                        acc_d = s;
                        if (k == N - 1) begin
                            res_d[i * N + j] = fit(s);
                            ck_d    = '0;
                            step_ij = 1'b1;
                        end else begin
                            ck_d = ck_q + 1'b1;
                        end
                    end
                    default: begin
                        s = ((ck_q == 2'd0) ? '0 : acc_q) + det_term;
                        acc_d = s;
                        if (k == N - 1) begin
                            res_d[0] = fit(s);
                            last     = 1'b1;
                        end else begin
                            ck_d = ck_q + 1'b1;
                        end
                    end
                endcase
                if (step_ij) begin
                    if (j == N - 1) begin
                        cj_d = '0;
                        if (i == N - 1) last = 1'b1;
                        else            ci_d = ci_q + 1'b1;
                    end else begin
                        cj_d = cj_q + 1'b1;
                    end
                end
                if (last) begin
                    state_d = S_OUT;
                    cnt_d   = '0;
                end
            end
            S_OUT: begin
                if ((op_q == 2'd3) || (cnt_q == CW'(NN - 1))) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cfg_q   <= '0;
            ci_q    <= '0;
            cj_q    <= '0;
            ck_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cfg_q   <= cfg_d;
            ci_q    <= ci_d;
            cj_q    <= cj_d;
            ck_q    <= ck_d;
        end
        rota_q <= rota_d;
        rotb_q <= rotb_d;
        op_q   <= op_d;
        acc_q  <= acc_d;
        a_q    <= a_d;
        b_q    <= b_d;
        wa_q   <= wa_d;
        wb_q   <= wb_d;
        res_q  <= res_d;
    end
endmodule

// File: tb/tb_matrix_engine.sv
// Bench for matrix_engine: vector table driven through a scoreboard on a 3x3 instance,
// plus hand-written reset and 2x2 sequences.
module tb_matrix_engine;
    localparam int DW = 5;
    localparam int OW = 16;

    logic CLK = 1'b0;
    logic RESET;
    logic vld3, vld2;
    logic signed [DW-1:0] in3, in2;
    logic rdy3, rdy2, ov3, ov2;
    logic signed [OW-1:0] out3, out2;

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    matrix_engine #(.N(3), .DW(DW), .OW(OW)) dut3 (
        .CLK(CLK), .RESET(RESET), .IN_VALID(vld3), .IN(in3),
        .IN_READY(rdy3), .OUT_VALID(ov3), .OUT(out3)
    );

    matrix_engine #(.N(2), .DW(DW), .OW(OW)) dut2 (
        .CLK(CLK), .RESET(RESET), .IN_VALID(vld2), .IN(in2),
        .IN_READY(rdy2), .OUT_VALID(ov2), .OUT(out2)
    );

    typedef int arr9_t[9];
    typedef struct {
        arr9_t a;
        arr9_t b;
        int    ra, rb, op;
        arr9_t e;
        int    nout, k, gaps;
    } vec_t;
    typedef struct {
        int val;
        int first;
    } sb_t;

    vec_t vt[12];
    sb_t  sbq[$];
    sb_t  mon_e;
    bit   mon_en = 1'b0;
    bit   exp_v;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_vec(input int idx, input arr9_t a, input arr9_t b, input int ra,
                           input int rb, input int op, input arr9_t e, input int nout,
                           input int k, input int gaps);
        vt[idx].a = a;   vt[idx].b = b;   vt[idx].ra = ra;  vt[idx].rb = rb;
        vt[idx].op = op; vt[idx].e = e;   vt[idx].nout = nout;
        vt[idx].k = k;   vt[idx].gaps = gaps;
    endtask

    task automatic set_in(input int d, input bit v, input int x);
        if (d == 3) begin
            vld3 = v;
            in3  = DW'(x);
        end else begin
            vld2 = v;
            in2  = DW'(x);
        end
    endtask

    // Drives n beats one per cycle; returns at the negedge after the last accepting edge.
    task automatic send(input int d, input int bt[21], input int n, input int gaps, output int t);
        for (int b = 0; b < n; b++) begin
            @(negedge CLK);
            set_in(d, 1'b1, bt[b]);
            @(posedge CLK);
            if (gaps != 0 && (b == 3 || b == 11 || b == 18)) begin
                repeat (3) begin
                    @(negedge CLK);
                    set_in(d, 1'b0, int'($urandom_range(0, 31)));
                    @(posedge CLK);
                end
            end
        end
        @(negedge CLK);
        set_in(d, 1'b0, 0);
        t = cyc;
    endtask

    // IN_VALID with random data while the engine is busy must be ignored.
    task automatic junk(input int d);
        repeat (3) begin
            set_in(d, 1'b1, int'($urandom_range(0, 31)));
            @(negedge CLK);
        end
        set_in(d, 1'b0, 0);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((sbq.size() != 0 || !rdy3) && w < 400) begin
            @(negedge CLK);
            w++;
        end
        chk("idle_reached", (w < 400), 1);
    endtask

    task automatic run_vec(input int idx);
        int  bt[21];
        int  t;
        sb_t s;
        wait_idle();
        for (int i = 0; i < 9; i++) begin
            bt[i]     = vt[idx].a[i];
            bt[9 + i] = vt[idx].b[i];
        end
        bt[18] = vt[idx].ra;
        bt[19] = vt[idx].rb;
        bt[20] = vt[idx].op;
        send(3, bt, 21, vt[idx].gaps, t);
        chk("ready_low_after_cfg", rdy3, 0);
        for (int q = 0; q < vt[idx].nout; q++) begin
            s.val   = vt[idx].e[q];
            s.first = (q == 0) ? t + vt[idx].k + 1 : -1;
            sbq.push_back(s);
        end
        junk(3);
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            exp_v = (sbq.size() > 0) && ((sbq[0].first < 0) || (sbq[0].first == cyc));
            chk("out_valid", ov3, exp_v);
            if (ov3 && sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                chk("out_value", out3, mon_e.val);
            end else if (!ov3) begin
                chk("out_zero_idle", out3, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        arr9_t seq, ones, zer, idm, m8, s7, d234, d8, gen;
        int    bt2[21];
        int    t, w;
        seq  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        ones = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        zer  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        idm  = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        m8   = '{-8, -8, -8, -8, -8, -8, -8, -8, -8};
        s7   = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
        d234 = '{2, 0, 0, 0, 3, 0, 0, 0, 4};
        d8   = '{-8, 0, 0, 0, -8, 0, 0, 0, -8};
        gen  = '{1, 2, 3, 4, 5, 6, 7, 8, 10};

        set_vec(0,  seq,  ones, 0, 0, 0, '{2, 3, 4, 5, 6, 7, 8, 9, 10}, 9, 9, 0);
        set_vec(1,  seq,  idm,  1, 0, 2, '{7, 4, 1, 8, 5, 2, 9, 6, 3}, 9, 27, 0);
        set_vec(2,  m8,   s7,   0, 0, 1, '{-15, -15, -15, -15, -15, -15, -15, -15, -15}, 9, 9, 0);
        set_vec(3,  m8,   m8,   0, 0, 2, '{192, 192, 192, 192, 192, 192, 192, 192, 192}, 9, 27, 0);
        set_vec(4,  d234, seq,  0, 0, 3, '{24, 0, 0, 0, 0, 0, 0, 0, 0}, 1, 3, 0);
        set_vec(5,  d8,   ones, 0, 2, 3, '{-512, 0, 0, 0, 0, 0, 0, 0, 0}, 1, 3, 0);
        set_vec(6,  seq,  ones, 0, 0, 0, '{2, 3, 4, 5, 6, 7, 8, 9, 10}, 9, 9, 1);
        set_vec(7,  seq,  zer,  6, 0, -4, '{9, 8, 7, 6, 5, 4, 3, 2, 1}, 9, 9, 0);
        set_vec(8,  zer,  seq,  0, 3, 1, '{-3, -6, -9, -2, -5, -8, -1, -4, -7}, 9, 9, 0);
        set_vec(9,  d234, zer,  1, 0, 3, '{-24, 0, 0, 0, 0, 0, 0, 0, 0}, 1, 3, 0);
        set_vec(10, gen,  zer,  0, 0, 3, '{-3, 0, 0, 0, 0, 0, 0, 0, 0}, 1, 3, 0);
        set_vec(11, seq,  seq,  0, 0, 2, '{30, 36, 42, 66, 81, 96, 102, 126, 150}, 9, 27, 0);

        RESET = 1'b1;
        vld3 = 1'b0;  vld2 = 1'b0;  in3 = '0;  in2 = '0;
        repeat (3) @(negedge CLK);
        chk("reset_ready3", rdy3, 1);
        chk("reset_out_valid3", ov3, 0);
        chk("reset_out3", out3, 0);
        chk("reset_ready2", rdy2, 1);
        chk("reset_out_valid2", ov2, 0);
        chk("reset_out2", out2, 0);
        RESET  = 1'b0;
        mon_en = 1'b1;

        for (int v = 0; v < 12; v++) run_vec(v);

        // Reset during the 5th output beat of an add burst.
        wait_idle();
        mon_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bt2[i]     = seq[i];
            bt2[9 + i] = ones[i];
        end
        bt2[18] = 0;  bt2[19] = 0;  bt2[20] = 0;
        send(3, bt2, 21, 0, t);
        junk(3);
        w = 0;
        while (!ov3 && w < 100) begin
            @(negedge CLK);
            w++;
        end
        chk("reset_seq_burst_start", ov3, 1);
        repeat (4) @(negedge CLK);
        chk("reset_seq_fifth_beat", out3, 6);
        RESET = 1'b1;
        set_in(3, 1'b1, 5);
        @(negedge CLK);
        chk("post_reset_out_valid", ov3, 0);
        chk("post_reset_out", out3, 0);
        chk("post_reset_ready", rdy3, 1);
        RESET = 1'b0;
        set_in(3, 1'b0, 0);
        mon_en = 1'b1;
        run_vec(4);

        // 2x2 instance: reset mid-load with a simultaneous beat, then a fresh det load.
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            set_in(2, 1'b1, 9);
            @(posedge CLK);
        end
        @(negedge CLK);
        RESET = 1'b1;
        set_in(2, 1'b1, 5);
        @(negedge CLK);
        RESET = 1'b0;
        set_in(2, 1'b0, 0);
        chk("midload_reset_ready2", rdy2, 1);
        chk("midload_reset_out_valid2", ov2, 0);
        for (int i = 0; i < 21; i++) bt2[i] = 0;
        bt2[0] = 1;  bt2[1] = 2;  bt2[2] = 3;  bt2[3] = 4;  bt2[10] = 3;
        send(2, bt2, 11, 0, t);
        chk("n2_ready_low_after_cfg", rdy2, 0);
        junk(2);
        w = 0;
        while (!ov2 && w < 20) begin
            @(negedge CLK);
            w++;
        end
        chk("n2_det_first_cycle", cyc, t + 3);
        chk("n2_det_value", out2, -2);
        @(negedge CLK);
        chk("n2_det_single_beat", ov2, 0);
        chk("n2_out_zero_after", out2, 0);
        chk("n2_ready_after_out", rdy2, 1);

        wait_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
